// File: rtl/multicycle_ctrl.sv
// Multicycle instruction controller: FETCH/DECODE/EXEC/MEM/WB sequencing with memory wait-timeout.
// Optional macro ILLEGAL_TRAP_EN sends illegal opcodes to a sticky TRAP state instead of treating them as NOPs.
module multicycle_ctrl #(
    parameter int MAX_WAIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       w_data,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       w_reg,
    output logic       store,
    output logic [5:0] op_alu,
    output logic [2:0] state,
    output logic       instr_done,
    output logic       mem_err
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic is_add, is_addi, is_lw, is_sw, is_beq, is_j, is_legal;
    logic timeout;

    logic       mem_req_c, w_data_c, ir_we_c, pc_we_c, w_reg_c, store_c;
    logic       instr_done_c, mem_err_c;
    logic [1:0] pc_src_c;
    logic [5:0] op_alu_c;

    assign is_add   = (op == 6'b000000) && (funct == 6'b100000);
    assign is_addi  = (op == 6'b001000);
    assign is_lw    = (op == 6'b100011);
    assign is_sw    = (op == 6'b101011);
    assign is_beq   = (op == 6'b000100);
    assign is_j     = (op == 6'b000010);
    assign is_legal = is_add | is_addi | is_lw | is_sw | is_beq | is_j;

    // A completion in the same cycle as the limit is reached wins over the timeout.
    assign timeout = (cnt_q == CNT_MAX) && !mem_ready;

    always_comb begin
        state_d      = state_q;
        mem_req_c    = 1'b0;
        w_data_c     = 1'b0;
        ir_we_c      = 1'b0;
        pc_we_c      = 1'b0;
        pc_src_c     = 2'd0;
        w_reg_c      = 1'b0;
        store_c      = 1'b0;
        op_alu_c     = 6'd0;
        instr_done_c = 1'b0;
        mem_err_c    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_we_c = 1'b1;
                    pc_we_c = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    mem_err_c = 1'b1;
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    state_d = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    instr_done_c = 1'b1;
                    state_d      = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                store_c = 1'b1;
                state_d = S_FETCH;
                if (is_add) begin
                    state_d = S_WB;
                end else if (is_addi) begin
                    op_alu_c = 6'd1;
                    state_d  = S_WB;
                end else if (is_lw) begin
                    op_alu_c = 6'd2;
                    state_d  = S_MEM;
                end else if (is_sw) begin
                    op_alu_c = 6'd3;
                    state_d  = S_MEM;
                end else if (is_beq) begin
                    op_alu_c     = 6'd4;
                    pc_we_c      = zero;
                    pc_src_c     = 2'd1;
                    instr_done_c = 1'b1;
                end else if (is_j) begin
                    pc_we_c      = 1'b1;
                    pc_src_c     = 2'd2;
                    instr_done_c = 1'b1;
                end
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                w_data_c  = is_sw;
                if (mem_ready) begin
                    if (is_sw) begin
                        instr_done_c = 1'b1;
                        state_d      = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    mem_err_c = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_WB: begin
                w_reg_c      = 1'b1;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                state_d = S_TRAP;
`else
                state_d = S_FETCH;
`endif
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Counter is zero everywhere except while a memory access is waiting.
    always_comb begin
        cnt_d = '0;
        if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready && !timeout)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_req    = mem_req_c & ~rst;
    assign w_data     = w_data_c & ~rst;
    assign ir_we      = ir_we_c & ~rst;
    assign pc_we      = pc_we_c & ~rst;
    assign pc_src     = rst ? 2'd0 : pc_src_c;
    assign w_reg      = w_reg_c & ~rst;
    assign store      = store_c & ~rst;
    assign op_alu     = rst ? 6'd0 : op_alu_c;
    assign state      = rst ? 3'd0 : state_q;
    assign instr_done = instr_done_c & ~rst;
    assign mem_err    = mem_err_c & ~rst;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench: an instruction-level model expands each instruction into its expected
// per-cycle output trace (phases, waits, timeouts), which is replayed against the controller.
module tb_multicycle_ctrl;

    localparam int MW = 8;
    localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23,
                           OP_SW = 6'h2b, OP_BEQ = 6'h04, OP_J = 6'h02;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       mem_req, w_data, ir_we, pc_we, w_reg, store, instr_done, mem_err;
    logic [1:0] pc_src;
    logic [5:0] op_alu;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_ctrl #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .w_data(w_data), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .w_reg(w_reg), .store(store), .op_alu(op_alu), .state(state),
        .instr_done(instr_done), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        rdy;
        logic [5:0]  o;
        logic [5:0]  f;
        logic        z;
        logic [18:0] e;
        string       tag;
    } rec_t;

    rec_t trace[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Field order: req wdata ir_we pc_we pc_src w_reg store op_alu state done err
    function automatic logic [18:0] mk(input logic req, wd, ir, pcw, input logic [1:0] pcs,
                                       input logic wr, st, input logic [5:0] alu,
                                       input logic [2:0] stt, input logic done, err);
        return {req, wd, ir, pcw, pcs, wr, st, alu, stt, done, err};
    endfunction

    task automatic push(input string tag, input logic r, rdy, input logic [5:0] o, f,
                        input logic z, input logic [18:0] e);
        trace.push_back('{r, rdy, o, f, z, e, tag});
    endtask

    function automatic logic rnd1();
        return 1'($urandom);
    endfunction

    function automatic logic [5:0] rnd6();
        return 6'($urandom);
    endfunction

    // Memory phase of n idle cycles: the access times out after MW waits.
    task automatic push_timeout(input string tag, input logic [5:0] o, f, input logic z,
                                input logic wd, input logic [2:0] stt, input logic fetch);
        for (int i = 0; i < MW; i++)
            push(tag, 0, 0, fetch ? rnd6() : o, fetch ? rnd6() : f, z,
                 mk(1, wd, 0, 0, 0, 0, 0, 0, stt, 0, 0));
        push({tag, "_err"}, 0, 0, fetch ? rnd6() : o, fetch ? rnd6() : f, z,
             mk(1, wd, 0, 0, 0, 0, 0, 0, stt, 0, 1));
    endtask

    task automatic build_instr(input string tag, input logic [5:0] o, f, input logic z,
                               input int fw, input bit fetch_to, input int mw, input bit mem_to);
        logic [5:0] alu;
        logic       wd;
        bit         legal;
        if (fetch_to) push_timeout({tag, "_fto"}, o, f, z, 0, 3'd0, 1);
        for (int i = 0; i < fw; i++)
            push({tag, "_fwait"}, 0, 0, rnd6(), rnd6(), z, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push({tag, "_fetch"}, 0, 1, rnd6(), rnd6(), z, mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        legal = (o == OP_R && f == 6'h20) || o == OP_ADDI || o == OP_LW ||
                o == OP_SW || o == OP_BEQ || o == OP_J;
        if (!legal) begin
`ifdef ILLEGAL_TRAP_EN
            push({tag, "_dec"}, 0, rnd1(), o, f, z, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
            for (int i = 0; i < 5; i++)
                push({tag, "_trap"}, 0, rnd1(), rnd6(), rnd6(), rnd1(),
                     mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0));
            push({tag, "_rst"}, 1, 1, o, f, z, '0);
`else
            push({tag, "_nop"}, 0, rnd1(), o, f, z, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
`endif
            return;
        end
        push({tag, "_dec"}, 0, rnd1(), o, f, z, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        if (o == OP_BEQ) begin
            push({tag, "_beq"}, 0, rnd1(), o, f, z, mk(0, 0, 0, z, 1, 0, 1, 4, 2, 1, 0));
            return;
        end
        if (o == OP_J) begin
            push({tag, "_j"}, 0, rnd1(), o, f, z, mk(0, 0, 0, 1, 2, 0, 1, 0, 2, 1, 0));
            return;
        end
        alu = (o == OP_ADDI) ? 6'd1 : (o == OP_LW) ? 6'd2 : (o == OP_SW) ? 6'd3 : 6'd0;
        push({tag, "_exec"}, 0, rnd1(), o, f, z, mk(0, 0, 0, 0, 0, 0, 1, alu, 2, 0, 0));
        if (o == OP_LW || o == OP_SW) begin
            wd = (o == OP_SW);
            if (mem_to) begin
                push_timeout({tag, "_mto"}, o, f, z, wd, 3'd3, 0);
                return;
            end
            for (int i = 0; i < mw; i++)
                push({tag, "_mwait"}, 0, 0, o, f, z, mk(1, wd, 0, 0, 0, 0, 0, 0, 3, 0, 0));
            push({tag, "_mem"}, 0, 1, o, f, z, mk(1, wd, 0, 0, 0, 0, 0, 0, 3, wd, 0));
            if (wd) return;
        end
        push({tag, "_wb"}, 0, rnd1(), o, f, z, mk(0, 0, 0, 0, 0, 1, 0, 0, 4, 1, 0));
    endtask

    task automatic run_trace();
        rec_t rc;
        while (trace.size() > 0) begin
            rc = trace.pop_front();
            rst = rc.r; mem_ready = rc.rdy; op = rc.o; funct = rc.f; zero = rc.z;
            @(negedge clk);
            check_eq(rc.tag, 32'({mem_req, w_data, ir_we, pc_we, pc_src, w_reg, store,
                                  op_alu, state, instr_done, mem_err}), 32'(rc.e));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [5:0] o, f;
        int         k;
        rst = 1'b1; mem_ready = 1'b1; op = OP_SW; funct = 6'h20; zero = 1'b1;
        @(posedge clk);
        #1;
        push("reset", 1, 1, OP_SW, 6'h20, 1, '0);
        push("reset2", 1, 1, OP_LW, 6'h00, 0, '0);
        run_trace();

        // Directed scenarios
        build_instr("add", OP_R, 6'h20, 0, 0, 0, 0, 0);
        build_instr("lw_w3", OP_LW, 6'h11, 0, 0, 0, 3, 0);
        build_instr("beq_z1", OP_BEQ, 6'h00, 1, 0, 0, 0, 0);
        build_instr("beq_z0", OP_BEQ, 6'h00, 0, 0, 0, 0, 0);
        build_instr("sw_to", OP_SW, 6'h05, 0, 0, 0, 0, 1);
        build_instr("fetch_max", OP_ADDI, 6'h00, 0, MW, 0, MW, 0);
        build_instr("lw_memmax", OP_LW, 6'h00, 1, 0, 1, MW, 0);
        build_instr("j", OP_J, 6'h3f, 1, 1, 0, 0, 0);
        build_instr("illegal", 6'h3f, 6'h20, 0, 0, 0, 0, 0);
        build_instr("bad_funct", OP_R, 6'h21, 0, 0, 0, 0, 0);
        run_trace();

        // Reset in MEM of a store, then a fetch timeout proves the counter restarted at 0
        push("sw_fetch", 0, 1, rnd6(), rnd6(), 0, mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        push("sw_dec", 0, 0, OP_SW, 6'h0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        push("sw_exec", 0, 0, OP_SW, 6'h0, 0, mk(0, 0, 0, 0, 0, 0, 1, 3, 2, 0, 0));
        push("sw_mwait", 0, 0, OP_SW, 6'h0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0));
        push("sw_mwait", 0, 0, OP_SW, 6'h0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0));
        push("sw_rst", 1, 1, OP_SW, 6'h0, 0, '0);
        build_instr("post_rst", OP_R, 6'h20, 0, 0, 1, 0, 0);
        // Reset in the middle of a waiting fetch
        for (int i = 0; i < 5; i++)
            push("f_wait", 0, 0, rnd6(), rnd6(), 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push("f_rst", 1, 0, rnd6(), rnd6(), 0, '0);
        build_instr("post_frst", OP_ADDI, 6'h00, 1, 2, 1, 0, 0);
        run_trace();

        // Random instruction stream
        for (int n = 0; n < 120; n++) begin
            k = $urandom_range(0, 6);
            f = rnd6();
            case (k)
                0: begin o = OP_R; f = 6'h20; end
                1: o = OP_ADDI;
                2: o = OP_LW;
                3: o = OP_SW;
                4: o = OP_BEQ;
                5: o = OP_J;
                default: begin
                    o = rnd6();
                    if (o == OP_ADDI || o == OP_LW || o == OP_SW || o == OP_BEQ || o == OP_J)
                        o = 6'h3f;
                    if (o == OP_R && f == 6'h20) f = 6'h21;
                end
            endcase
            build_instr($sformatf("rnd%0d", n), o, f, rnd1(), $urandom_range(0, MW),
                        $urandom_range(0, 9) == 0, $urandom_range(0, MW),
                        $urandom_range(0, 7) == 0);
            run_trace();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
